// File: rtl/jtframe_spi_loader.sv
// SPI master emulating the MC2 I/O controller ROM download:
// sends start frame, data frame from a byte source, end frame.
module jtframe_spi_loader #(
  parameter int CLKDIV = 4,
  parameter int SS_GAP = 8
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        start,
  input  logic [21:0] len,
  output logic        src_req,
  output logic [21:0] src_addr,
  input  logic        src_ok,
  input  logic [7:0]  src_data,
  output logic        busy,
  output logic        done,
  output logic        SPI_SS2,
  output logic        SPI_SCK,
  output logic        SPI_DI
);

  typedef enum logic [2:0] {
    IDLE, SEL_A, GAP_A, SEL_B, GAP_B, SEL_C
  } state_t;

  state_t      state, state_nx;
  logic [15:0] div, div_nx;
  logic [15:0] gcnt, gcnt_nx;
  logic [2:0]  bitc, bitc_nx;
  logic [21:0] bytec, bytec_nx;
  logic [21:0] len_r, len_nx;
  logic [7:0]  sh, sh_nx;
  logic [7:0]  buf_d, buf_nx;
  logic        buf_full, buf_full_nx;
  logic        stall, stall_nx;
  logic        req_nx, busy_nx, done_nx;
  logic        ss2_nx, sck_nx, di_nx;
  logic [21:0] addr_nx;

  logic        load, last, avail;
  logic [21:0] load_j;
  logic [7:0]  din, b;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= '0;
      gcnt     <= '0;
      bitc     <= '0;
      bytec    <= '0;
      len_r    <= '0;
      sh       <= '0;
      buf_d    <= '0;
      buf_full <= 1'b0;
      stall    <= 1'b0;
      src_req  <= 1'b0;
      src_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      SPI_SS2  <= 1'b1;
      SPI_SCK  <= 1'b0;
      SPI_DI   <= 1'b0;
    end else begin
      state    <= state_nx;
      div      <= div_nx;
      gcnt     <= gcnt_nx;
      bitc     <= bitc_nx;
      bytec    <= bytec_nx;
      len_r    <= len_nx;
      sh       <= sh_nx;
      buf_d    <= buf_nx;
      buf_full <= buf_full_nx;
      stall    <= stall_nx;
      src_req  <= req_nx;
      src_addr <= addr_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      SPI_SS2  <= ss2_nx;
      SPI_SCK  <= sck_nx;
      SPI_DI   <= di_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    div_nx      = div;
    gcnt_nx     = gcnt;
    bitc_nx     = bitc;
    bytec_nx    = bytec;
    len_nx      = len_r;
    sh_nx       = sh;
    buf_nx      = buf_d;
    buf_full_nx = buf_full;
    stall_nx    = stall;
    req_nx      = src_req;
    addr_nx     = src_addr;
    busy_nx     = busy;
    done_nx     = 1'b0;
    ss2_nx      = SPI_SS2;
    sck_nx      = SPI_SCK;
    di_nx       = SPI_DI;
    load        = 1'b0;
    load_j      = bytec + 22'd1;
    b           = 8'h53;
    avail       = buf_full | (src_req & src_ok);
    din         = buf_full ? buf_d : src_data;
    last        = (state == SEL_B) ? (bytec == len_r)
                                   : (bytec == 22'd1);

    if (src_req && src_ok) begin
      req_nx      = 1'b0;
      buf_nx      = src_data;
      buf_full_nx = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (start && !done) begin
          len_nx      = len;
          busy_nx     = 1'b1;
          ss2_nx      = 1'b0;
          buf_full_nx = 1'b0;
          state_nx    = SEL_A;
          load        = 1'b1;
          load_j      = '0;
        end
      end
      GAP_A, GAP_B: begin
        if (gcnt == 16'(SS_GAP - 1)) begin
          gcnt_nx  = '0;
          ss2_nx   = 1'b0;
          load     = 1'b1;
          load_j   = '0;
          state_nx = (state == GAP_B || len_r == '0) ? SEL_C : SEL_B;
        end else begin
          gcnt_nx = gcnt + 16'd1;
        end
      end
      default: begin
        if (stall) begin
          if (avail) begin
            stall_nx = 1'b0;
            load     = 1'b1;
          end
        end else if (div == 16'(CLKDIV - 1)) begin
          div_nx = '0;
          sck_nx = !SPI_SCK;
          if (SPI_SCK) begin
            if (bitc != 3'd7) begin
              bitc_nx = bitc + 3'd1;
              sh_nx   = {sh[6:0], 1'b0};
              di_nx   = sh[6];
            end else if (last) begin
              ss2_nx  = 1'b1;
              gcnt_nx = '0;
              if (state == SEL_C) begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
              end else begin
                state_nx = (state == SEL_A) ? GAP_A : GAP_B;
              end
            end else if (state == SEL_B && !avail) begin
              // underrun: park with SCK low until the byte arrives
              stall_nx = 1'b1;
            end else begin
              load = 1'b1;
            end
          end
        end else begin
          div_nx = div + 16'd1;
        end
      end
    endcase

    if (load) begin
      if (state_nx == SEL_A)
        b = (load_j == '0) ? 8'h53 : 8'hFF;
      else if (state_nx == SEL_C)
        b = (load_j == '0) ? 8'h53 : 8'h00;
      else
        b = (load_j == '0) ? 8'h54 : din;
      if (state_nx == SEL_B) begin
        if (load_j != '0) buf_full_nx = 1'b0;
        // prefetch the byte after the one now starting
        if (load_j < len_nx) begin
          req_nx  = 1'b1;
          addr_nx = load_j;
        end
      end
      sh_nx    = b;
      di_nx    = b[7];
      div_nx   = '0;
      bitc_nx  = '0;
      bytec_nx = load_j;
      sck_nx   = 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_spi_loader.sv
// Directed bench for jtframe_spi_loader: SPI slave decoder,
// byte source model, timing and reset checks on two dividers.
`timescale 1ns/1ps
module tb_jtframe_spi_loader;

  localparam int NCH = 2;
  localparam logic [63:0] RST = 64'h800_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start[NCH];
  logic [21:0] len[NCH];
  logic        busy[NCH], done[NCH];
  logic        ss2[NCH], sck[NCH], di[NCH];
  logic        src_req[NCH];
  logic [21:0] src_addr[NCH];
  logic [7:0]  mem[NCH][4];
  int          dly1[NCH];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int CK = (g == 0) ? 4 : 2;
    logic        src_ok;
    logic [7:0]  src_data;
    logic [63:0] fr_q[$];
    int          ml_q[$];
    int          fall_q[$];
    logic [21:0] addr_q[$];
    int rises = 0, bad_ph = 0, bad_di = 0;
    int n_done = 0, last_done = 0;

    jtframe_spi_loader #(.CLKDIV(CK), .SS_GAP(8)) u_dut (
      .clk_sys (clk),
      .rst_n   (rst_n),
      .start   (start[g]),
      .len     (len[g]),
      .src_req (src_req[g]),
      .src_addr(src_addr[g]),
      .src_ok  (src_ok),
      .src_data(src_data),
      .busy    (busy[g]),
      .done    (done[g]),
      .SPI_SS2 (ss2[g]),
      .SPI_SCK (sck[g]),
      .SPI_DI  (di[g])
    );

    initial begin : src
      logic [21:0] a;
      src_ok = 1'b0;
      src_data = '0;
      forever begin
        @(negedge clk);
        if (rst_n && src_req[g]) begin
          a = src_addr[g];
          addr_q.push_back(a);
          repeat ((a == 22'd1) ? dly1[g] : 2) @(negedge clk);
          src_ok = 1'b1;
          src_data = mem[g][a[1:0]];
          @(negedge clk);
          src_ok = 1'b0;
        end
      end
    end

    initial begin : mon
      logic psck, pss2, pdi, in_fr;
      logic [7:0] sh;
      logic [63:0] cur;
      int nbits, run, mlo;
      psck = 0; pss2 = 1; pdi = 0; in_fr = 0;
      sh = 0; cur = 0; nbits = 0; run = 0; mlo = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          in_fr = 0;
        end else begin
          if (done[g]) begin
            n_done++;
            last_done = cyc;
          end
          if (pss2 && !ss2[g]) begin
            in_fr = 1; cur = 0; nbits = 0; run = 0; mlo = 0;
            fall_q.push_back(cyc);
          end
          if (in_fr) begin
            if (sck[g] == psck) run++;
            else begin
              if (run != CK) bad_ph++;
              if (sck[g]) begin
                if (run > mlo) mlo = run;
                rises++;
                if (di[g] !== pdi) bad_di++;
                sh = {sh[6:0], di[g]};
                nbits++;
                if (nbits % 8 == 0) cur = {cur[55:0], sh};
              end
              run = 1;
            end
            if (!pss2 && ss2[g]) begin
              fr_q.push_back({8'(nbits), cur[55:0]});
              ml_q.push_back(mlo);
              in_fr = 0;
            end
          end
        end
        psck = sck[g]; pss2 = ss2[g]; pdi = di[g];
      end
    end
  end

  function automatic logic [63:0] fx(input int nb, input logic [55:0] v);
    return {8'(nb), v};
  endfunction

  function automatic int fsz(input int k);
    return (k == 0) ? g_ch[0].fr_q.size() : g_ch[1].fr_q.size();
  endfunction

  function automatic logic [63:0] frm(input int k, input int i);
    if (i >= fsz(k)) return '1;
    return (k == 0) ? g_ch[0].fr_q[i] : g_ch[1].fr_q[i];
  endfunction

  function automatic int fall_at(input int k, input int i);
    if (k == 0) return (i < g_ch[0].fall_q.size()) ? g_ch[0].fall_q[i] : -1;
    return (i < g_ch[1].fall_q.size()) ? g_ch[1].fall_q[i] : -1;
  endfunction

  function automatic int falls(input int k);
    return (k == 0) ? g_ch[0].fall_q.size() : g_ch[1].fall_q.size();
  endfunction

  function automatic logic [21:0] addr_at(input int i);
    return (i < g_ch[0].addr_q.size()) ? g_ch[0].addr_q[i] : '1;
  endfunction

  function automatic int ml_at(input int i);
    return (i < g_ch[0].ml_q.size()) ? g_ch[0].ml_q[i] : -1;
  endfunction

  function automatic logic [63:0] outs(input int k);
    return {36'd0, ss2[k], sck[k], di[k], src_req[k],
            busy[k], done[k], src_addr[k]};
  endfunction

  task automatic pulse(input int k, input logic [21:0] l);
    len[k] = l;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic go(input int k, input logic [21:0] l, output int c0);
    @(negedge clk);
    c0 = cyc;
    pulse(k, l);
  endtask

  task automatic wait_done(input int k, input int lim);
    int n = 0;
    while (!done[k] && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen%0d", k), 64'(done[k]), 64'd1);
  endtask

  initial begin
    int c0, fb, fl, ab, pb, db, rb, nd;
    rst_n = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      start[k] = 1'b0;
      len[k] = '0;
      dly1[k] = 2;
      for (int i = 0; i < 4; i++) mem[k][i] = '0;
    end
    repeat (4) @(negedge clk);
    chk("rst_outs0", outs(0), RST);
    chk("rst_outs1", outs(1), RST);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mem[0][0] = 8'hA5; mem[0][1] = 8'h3C; mem[0][2] = 8'h81;
    fb = fsz(0); fl = falls(0); ab = g_ch[0].addr_q.size();
    pb = g_ch[0].bad_ph;
    go(0, 22'd3, c0);
    wait_done(0, 2000);
    chk("t1_nfr", 64'(fsz(0) - fb), 64'd3);
    chk("t1_frA", frm(0, fb), fx(16, 56'h53FF));
    chk("t1_frB", frm(0, fb + 1), fx(32, 56'h54A53C81));
    chk("t1_frC", frm(0, fb + 2), fx(16, 56'h5300));
    chk("t1_sslat", 64'(fall_at(0, fl) - c0), 64'd1);
    chk("t1_len", 64'(g_ch[0].last_done - fall_at(0, fl)), 64'd528);
    chk("t1_nreq", 64'(g_ch[0].addr_q.size() - ab), 64'd3);
    chk("t1_a0", 64'(addr_at(ab)), 64'd0);
    chk("t1_a1", 64'(addr_at(ab + 1)), 64'd1);
    chk("t1_a2", 64'(addr_at(ab + 2)), 64'd2);
    chk("t1_phase", 64'(g_ch[0].bad_ph - pb), 64'd0);
    chk("t1_busy", 64'(busy[0]), 64'd0);

    fb = fsz(0); fl = falls(0); ab = g_ch[0].addr_q.size();
    go(0, 22'd0, c0);
    wait_done(0, 2000);
    chk("t2_nfr", 64'(fsz(0) - fb), 64'd2);
    chk("t2_frA", frm(0, fb), fx(16, 56'h53FF));
    chk("t2_frC", frm(0, fb + 1), fx(16, 56'h5300));
    chk("t2_nreq", 64'(g_ch[0].addr_q.size() - ab), 64'd0);
    chk("t2_len", 64'(g_ch[0].last_done - fall_at(0, fl)), 64'd264);

    dly1[0] = 200;
    fb = fsz(0); fl = falls(0); rb = g_ch[0].rises;
    go(0, 22'd2, c0);
    wait_done(0, 3000);
    dly1[0] = 2;
    chk("t3_nfr", 64'(fsz(0) - fb), 64'd3);
    chk("t3_frB", frm(0, fb + 1), fx(24, 56'h54A53C));
    chk("t3_frC", frm(0, fb + 2), fx(16, 56'h5300));
    chk("t3_stall", 64'(ml_at(fb + 1)), 64'd141);
    chk("t3_rises", 64'(g_ch[0].rises - rb), 64'd56);
    chk("t3_len", 64'(g_ch[0].last_done - fall_at(0, fl)), 64'd601);

    fb = fsz(0);
    go(0, 22'd3, c0);
    repeat (230) @(negedge clk);
    chk("t4_pre", 64'({busy[0], ss2[0]}), 64'b10);
    rst_n = 1'b0;
    #1;
    chk("t4_rst", outs(0), RST);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem[0][0] = 8'h5A;
    fl = fsz(0);
    go(0, 22'd1, c0);
    wait_done(0, 2000);
    chk("t4_nopart", 64'(fsz(0) - fb), 64'd4);
    chk("t4_frA", frm(0, fl), fx(16, 56'h53FF));
    chk("t4_frB", frm(0, fl + 1), fx(16, 56'h545A));
    chk("t4_frC", frm(0, fl + 2), fx(16, 56'h5300));

    mem[0][0] = 8'hA5; mem[0][1] = 8'h3C;
    fb = fsz(0); nd = g_ch[0].n_done;
    go(0, 22'd2, c0);
    repeat (50) @(negedge clk);
    pulse(0, 22'd5);
    repeat (300) @(negedge clk);
    pulse(0, 22'd5);
    wait_done(0, 2000);
    pulse(0, 22'd5);
    repeat (40) @(negedge clk);
    chk("t5_busy", 64'(busy[0]), 64'd0);
    chk("t5_ndone", 64'(g_ch[0].n_done - nd), 64'd1);
    chk("t5_nfr", 64'(fsz(0) - fb), 64'd3);
    chk("t5_frB", frm(0, fb + 1), fx(24, 56'h54A53C));

    mem[1][0] = 8'h00;
    fb = fsz(1); fl = falls(1);
    pb = g_ch[1].bad_ph; db = g_ch[1].bad_di; rb = g_ch[1].rises;
    go(1, 22'd1, c0);
    wait_done(1, 2000);
    chk("t6_len", 64'(g_ch[1].last_done - fall_at(1, fl)), 64'd208);
    mem[1][0] = 8'hFF;
    go(1, 22'd1, c0);
    wait_done(1, 2000);
    chk("t6_nfr", 64'(fsz(1) - fb), 64'd6);
    chk("t6_frA", frm(1, fb), fx(16, 56'h53FF));
    chk("t6_frB0", frm(1, fb + 1), fx(16, 56'h5400));
    chk("t6_frC", frm(1, fb + 2), fx(16, 56'h5300));
    chk("t6_frB1", frm(1, fb + 4), fx(16, 56'h54FF));
    chk("t6_phase", 64'(g_ch[1].bad_ph - pb), 64'd0);
    chk("t6_di", 64'(g_ch[1].bad_di - db), 64'd0);
    chk("t6_rises", 64'(g_ch[1].rises - rb), 64'd96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
